// File: rtl/mtds_spi_arbiter.sv
// mtds_spi_arbiter: two-requester round-robin arbiter in front of a
// mode-0 SPI master. A requester owns SS from its first byte until a byte
// flagged 'last' completes; bytes are full duplex, and the received byte is
// returned to the owner only.
module mtds_spi_arbiter #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    input  logic       mtds_rdy,
    output logic       ss_o,
    output logic       ss_t,
    output logic       sck_o,
    output logic       sck_t,
    output logic       io0_o,
    output logic       io0_t,
    output logic       io1_o,
    output logic       io1_t,
    input  logic       ss_i,
    input  logic       sck_i,
    input  logic       io0_i,
    input  logic       io1_i,
    output logic       busy,
    output logic       grant
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] CS_LAST  = SW'(CS_SETUP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [SW-1:0] cs_cnt;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic [7:0]    rsp_data;
    logic          last;
    logic          prio;       // requester that wins the next tie
    logic          pick;
    logic          own_valid;
    logic          own_last;
    logic [7:0]    own_data;

    // Only MISO is sampled; the other pad inputs are loop-back only.
    logic unused_pads;
    assign unused_pads = ss_i ^ sck_i ^ io0_i;

    assign ss_t      = 1'b0;
    assign sck_t     = 1'b0;
    assign io0_t     = 1'b0;
    assign io1_o     = 1'b0;
    assign io1_t     = 1'b1;
    assign io0_o     = tx[7];
    assign rsp0_data = rsp_data;
    assign rsp1_data = rsp_data;
    assign busy      = (state != IDLE);

    // Arbitration choice in IDLE and the current owner's request view.
    always_comb begin
        pick      = (req0_valid && req1_valid) ? prio : req1_valid;
        own_valid = grant ? req1_valid : req0_valid;
        own_last  = grant ? req1_last  : req0_last;
        own_data  = grant ? req1_data  : req0_data;
    end

    // Frame sequencer, SCK divider and shift registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            cs_cnt     <= '0;
            tx         <= '0;
            rx         <= '0;
            rsp_data   <= '0;
            last       <= 1'b0;
            prio       <= 1'b0;
            grant      <= 1'b0;
            ss_o       <= 1'b1;
            sck_o      <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mtds_rdy && (req0_valid || req1_valid)) begin
                        grant      <= pick;
                        prio       <= ~pick;
                        req0_ready <= ~pick;
                        req1_ready <= pick;
                        tx         <= pick ? req1_data : req0_data;
                        last       <= pick ? req1_last : req0_last;
                        ss_o       <= 1'b0;
                        cs_cnt     <= CS_LAST;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cs_cnt == '0) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cs_cnt <= cs_cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        sck_o   <= ~sck_o;
                        if (!sck_o) begin
                            rx <= {rx[6:0], io1_i};
                        end else begin
                            tx      <= {tx[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rsp_data   <= rx;
                                rsp0_valid <= ~grant;
                                rsp1_valid <= grant;
                                if (last) begin
                                    ss_o   <= 1'b1;
                                    cs_cnt <= CS_LAST;
                                    state  <= GAP;
                                end else if (own_valid) begin
                                    // back-to-back byte: overrides the shift above
                                    tx         <= own_data;
                                    last       <= own_last;
                                    req0_ready <= ~grant;
                                    req1_ready <= grant;
                                end else begin
                                    state <= HOLD;
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (own_valid) begin
                        tx         <= own_data;
                        last       <= own_last;
                        req0_ready <= ~grant;
                        req1_ready <= grant;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end
                GAP: begin
                    if (cs_cnt == '0) state <= IDLE;
                    else              cs_cnt <= cs_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mtds_spi_arbiter.sv
// Bench for mtds_spi_arbiter with MISO looped to MOSI. A negedge monitor
// logs transactions; a frame-level model predicts bytes, owner and timing.
module tb_mtds_spi_arbiter;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 2;
    localparam int BYTE_CYC = 16 * CLK_DIV;

    logic clk = 1'b0;
    logic resetn;
    logic req0_valid, req0_last, req1_valid, req1_last;
    logic [7:0] req0_data, req1_data;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_data, rsp1_data;
    logic mtds_rdy;
    logic ss_o, ss_t, sck_o, sck_t, io0_o, io0_t, io1_o, io1_t;
    logic ss_i, sck_i, io0_i, io1_i;
    logic busy, grant;

    assign io1_i = io0_o;
    assign ss_i  = 1'b1;
    assign sck_i = 1'b0;
    assign io0_i = 1'b0;

    always #5 clk = ~clk;

    mtds_spi_arbiter #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mtds_rdy(mtds_rdy),
        .ss_o(ss_o), .ss_t(ss_t), .sck_o(sck_o), .sck_t(sck_t),
        .io0_o(io0_o), .io0_t(io0_t), .io1_o(io1_o), .io1_t(io1_t),
        .ss_i(ss_i), .sck_i(sck_i), .io0_i(io0_i), .io1_i(io1_i),
        .busy(busy), .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int rsp_id_q[$];
    int rsp_d_q[$];
    int ss_run_q[$];
    int gap_q[$];
    int sck_rises = 0;
    int rdy_cnt0 = 0, rdy_cnt1 = 0;
    int viol = 0;
    int owner = -1;
    int run = 0, gap = 0;
    logic prev_sck = 1'b0, prev_ss = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (sck_o && !prev_sck) sck_rises++;
        if (!ss_o) begin
            if (prev_ss) begin run = 1; owner = -1; end
            else run++;
        end
        if (ss_o && !prev_ss) ss_run_q.push_back(run);
        if (ss_o && busy) gap++;
        if (!busy && prev_busy) begin gap_q.push_back(gap); gap = 0; end
        if (req0_ready) begin
            rdy_cnt0++;
            if (owner == -1) owner = 0; else if (owner != 0) viol++;
        end
        if (req1_ready) begin
            rdy_cnt1++;
            if (owner == -1) owner = 1; else if (owner != 1) viol++;
        end
        if (rsp0_valid) begin
            rsp_id_q.push_back(0); rsp_d_q.push_back(int'(rsp0_data));
            if (owner != 0) viol++;
        end
        if (rsp1_valid) begin
            rsp_id_q.push_back(1); rsp_d_q.push_back(int'(rsp1_data));
            if (owner != 1) viol++;
        end
        prev_sck  = sck_o;
        prev_ss   = ss_o;
        prev_busy = busy;
    end

    // ---------------- helpers ----------------
    int last_owner = -1;   // model: -1 means requester 0 wins a tie

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
        if (id == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
        else         begin req1_valid = v; req1_data = d; req1_last = l; end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            tick();
            if (!busy) break;
        end
        chk({tag, "_idle"}, (c < budget), 1);
    endtask

    // One frame of n bytes from requester id, next byte offered right after
    // each ready so no HOLD occurs.
    task automatic run_frame(input string tag, input int id, input int n, input logic [31:0] d,
                             input bit noise, input bit drop_rdy);
        int b_rsp, b_run, b_gap, r0, s0, v0, k, c;
        logic [31:0] dv;
        dv    = d;
        b_rsp = rsp_id_q.size(); b_run = ss_run_q.size(); b_gap = gap_q.size();
        r0    = (id == 0) ? rdy_cnt0 : rdy_cnt1;
        s0    = sck_rises; v0 = viol;
        set_req(id, 1'b1, dv[7:0], n == 1);
        for (k = 0; k < n; k++) begin
            for (c = 0; c < 4 * BYTE_CYC; c++) begin
                tick();
                if ((id == 0) ? req0_ready : req1_ready) break;
            end
            chk({tag, "_ready_seen"}, (c < 4 * BYTE_CYC), 1);
            if (k == 0 && drop_rdy) mtds_rdy = 1'b0;
            if (k == 0 && noise && n > 1) set_req(1 - id, 1'b1, 8'($urandom), 1'b1);
            if (k < n - 1) set_req(id, 1'b1, dv[8*(k+1) +: 8], (k + 1) == n - 1);
            else begin set_req(0, 1'b0, 8'h00, 1'b0); set_req(1, 1'b0, 8'h00, 1'b0); end
        end
        wait_idle(tag, 4 * BYTE_CYC);
        mtds_rdy = 1'b1;
        tick();
        chk({tag, "_rsp_count"}, rsp_id_q.size() - b_rsp, n);
        for (k = 0; k < n; k++) begin
            chk({tag, "_rsp_id"}, qget(rsp_id_q, b_rsp + k), id);
            chk({tag, "_rsp_data"}, qget(rsp_d_q, b_rsp + k), int'(dv[8*k +: 8]));
        end
        chk({tag, "_ss_low"}, qget(ss_run_q, b_run), CS_SETUP + BYTE_CYC * n);
        chk({tag, "_gap"}, qget(gap_q, b_gap), CS_SETUP);
        chk({tag, "_sck"}, sck_rises - s0, 8 * n);
        chk({tag, "_readies"}, ((id == 0) ? rdy_cnt0 : rdy_cnt1) - r0, n);
        chk({tag, "_nonowner"}, viol - v0, 0);
        chk({tag, "_grant"}, grant, id);
        last_owner = id;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b_rsp, b_run, b_gap, r1, c, v0;
        bit d0, d1, ok;
        resetn = 1'b0; mtds_rdy = 1'b1;
        set_req(0, 1'b0, 8'h00, 1'b0); set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        chk("rst_ss", ss_o, 1);
        chk("rst_sck", sck_o, 0);
        chk("rst_io0", io0_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", {req0_ready, req1_ready, rsp0_valid, rsp1_valid}, 0);
        chk("const_pads", {io1_o, io1_t, ss_t, sck_t, io0_t}, 5'b01000);
        resetn = 1'b1;
        tick();

        // Tie straight after reset: requester 0 first, then 1.
        b_rsp = rsp_id_q.size(); b_run = ss_run_q.size(); b_gap = gap_q.size();
        set_req(0, 1'b1, 8'h5A, 1'b1); set_req(1, 1'b1, 8'hC3, 1'b1);
        d0 = 0; d1 = 0;
        for (c = 0; c < 400; c++) begin
            tick();
            if (req0_ready) begin req0_valid = 1'b0; d0 = 1; end
            if (req1_ready) begin req1_valid = 1'b0; d1 = 1; end
            if (d0 && d1 && !busy) break;
        end
        chk("tie_done", (c < 400), 1);
        tick();
        chk("tie_first", qget(rsp_id_q, b_rsp), 0);
        chk("tie_second", qget(rsp_id_q, b_rsp + 1), 1);
        chk("tie_d0", qget(rsp_d_q, b_rsp), 8'h5A);
        chk("tie_d1", qget(rsp_d_q, b_rsp + 1), 8'hC3);
        chk("tie_ss0", qget(ss_run_q, b_run), CS_SETUP + BYTE_CYC);
        chk("tie_ss1", qget(ss_run_q, b_run + 1), CS_SETUP + BYTE_CYC);
        chk("tie_gap", qget(gap_q, b_gap), CS_SETUP);
        last_owner = 1;

        // Single-byte frame.
        run_frame("single", 0, 1, 32'h000000A5, 0, 0);

        // Two-byte frame with a 5-cycle HOLD; requester 1 waits meanwhile.
        b_rsp = rsp_id_q.size(); b_run = ss_run_q.size(); v0 = viol; r1 = rdy_cnt1;
        set_req(0, 1'b1, 8'h12, 1'b0);
        for (c = 0; c < 100; c++) begin tick(); if (req0_ready) break; end
        chk("hold_acc1", (c < 100), 1);
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h77; req1_last = 1'b1;
        for (c = 0; c < 100; c++) begin tick(); if (rsp0_valid) break; end
        chk("hold_rsp1", (c < 100), 1);
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ss_o !== 1'b0 || sck_o !== 1'b0 || busy !== 1'b1) ok = 0;
        end
        chk("hold_lines", ok, 1);
        set_req(0, 1'b1, 8'h34, 1'b1); req1_valid = 1'b0;
        for (c = 0; c < 100; c++) begin tick(); if (req0_ready) break; end
        chk("hold_acc2", (c < 100), 1);
        req0_valid = 1'b0;
        wait_idle("hold", 200);
        tick();
        chk("hold_d0", qget(rsp_d_q, b_rsp), 8'h12);
        chk("hold_d1", qget(rsp_d_q, b_rsp + 1), 8'h34);
        chk("hold_ids", qget(rsp_id_q, b_rsp) + qget(rsp_id_q, b_rsp + 1), 0);
        chk("hold_ss", qget(ss_run_q, b_run), CS_SETUP + 2 * BYTE_CYC + 6);
        chk("hold_nonowner", viol - v0 + rdy_cnt1 - r1, 0);
        last_owner = 0;

        // mtds_rdy low blocks arbitration; rising edge starts the frame.
        b_rsp = rsp_id_q.size(); r1 = rdy_cnt1;
        mtds_rdy = 1'b0;
        set_req(1, 1'b1, 8'h3C, 1'b1);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ss_o !== 1'b1 || busy !== 1'b0) ok = 0;
        end
        chk("rdy_low_idle", ok, 1);
        chk("rdy_low_noready", rdy_cnt1 - r1, 0);
        mtds_rdy = 1'b1;
        tick();
        chk("rdy_rise_ready", req1_ready, 1);
        chk("rdy_rise_ss", ss_o, 0);
        req1_valid = 1'b0;
        wait_idle("rdy", 200);
        tick();
        chk("rdy_data", qget(rsp_d_q, b_rsp), 8'h3C);
        chk("rdy_id", qget(rsp_id_q, b_rsp), 1);
        last_owner = 1;

        // Reset mid-byte aborts without a response.
        b_rsp = rsp_id_q.size();
        set_req(0, 1'b1, 8'hF0, 1'b1);
        for (c = 0; c < 100; c++) begin tick(); if (req0_ready) break; end
        chk("rst_acc", (c < 100), 1);
        req0_valid = 1'b0;
        repeat (14) tick();
        resetn = 1'b0;
        tick();
        chk("mid_rst_ss", ss_o, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sck", sck_o, 0);
        chk("mid_rst_grant", grant, 0);
        resetn = 1'b1;
        repeat (50) tick();
        chk("mid_rst_norsp", rsp_id_q.size() - b_rsp, 0);
        last_owner = -1;
        run_frame("after_rst", 1, 2, 32'h0000C0DE, 0, 0);

        // Randomised frames; mtds_rdy sometimes dropped mid-frame.
        for (int f = 0; f < 8; f++) begin
            int id, n;
            id = int'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 3));
            run_frame("rand", id, n, $urandom, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mtds_spi_arbiter.md
MTDS_SPI_ARBITER -- requirements
Module: mtds_spi_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCK half-period in clk cycles (legal values 1..255).
REQ-002 The block SHALL have parameter CS_SETUP, default 2, giving the SS-low-to-first-SCK time and the SS-high gap, in clk cycles (legal values 1..255).
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  reset, synchronous and active-low.
REQ-005 req0_valid, req1_valid  in  1 each  requester n has a byte to send.
REQ-006 req0_data, req1_data  in  8 each  byte to send, MSB first.
REQ-007 req0_last, req1_last  in  1 each  the byte is the final byte of a frame.
REQ-008 req0_ready, req1_ready  out  1 each  one-cycle pulse when the byte is accepted.
REQ-009 rsp0_valid/rsp0_data, rsp1_valid/rsp1_data  out  1/8 each  received byte and its one-cycle strobe.
REQ-010 mtds_rdy  in  1  MTDS ready flag, taken from the GPIO_IN_1 bit 0 path.
REQ-011 ss_o, ss_t, sck_o, sck_t, io0_o, io0_t, io1_o, io1_t  out  1 each  SPI pad-side outputs; these connect to the remap block's SPI_IN port.
REQ-012 ss_i, sck_i, io0_i, io1_i  in  1 each  SPI inputs; only io1_i (MISO) SHALL be used.
REQ-013 busy  out  1  high when the FSM is in any state other than IDLE.
REQ-014 grant  out  1  index of the current or most recent owner.

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-016 In IDLE, when mtds_rdy=1 and at least one reqN_valid=1, the block SHALL select the owner by round-robin (last owner loses a tie) and accept that byte.
REQ-017 Acceptance SHALL pulse reqN_ready for exactly one cycle and latch data and last.
REQ-018 In the same edge as acceptance, the block SHALL drive ss_o=0 and enter SETUP.
REQ-019 In IDLE with mtds_rdy=0, the block SHALL grant no requester and assert no ready.
REQ-020 SETUP SHALL last CS_SETUP cycles with sck_o=0, then go to SHIFT.
REQ-021 SHIFT SHALL use SPI mode 0: io0_o carries the current MSB while SCK is low.
REQ-022 In SHIFT, MISO SHALL be sampled into the receive shift register at each SCK rising edge.
REQ-023 In SHIFT, the transmit register SHALL shift at each SCK falling edge; one byte SHALL take exactly 16*CLK_DIV cycles.
REQ-024 After the 8th falling edge, the block SHALL pulse rspN_valid for one cycle to the owner only, with the 8 sampled bits (first sampled bit = bit 7).
REQ-025 At byte end with last=1, the block SHALL set ss_o=1, enter GAP for CS_SETUP cycles, then return to IDLE.
REQ-026 At byte end with last=0 and the owner's valid=1, the block SHALL accept the next byte in that same cycle and continue SHIFT with no SCK gap.
REQ-027 At byte end with last=0 and the owner's valid=0, the block SHALL enter HOLD (ss_o=0, sck_o=0).
REQ-028 In HOLD, the block SHALL accept the owner's next byte when it becomes valid and re-enter SHIFT on the next cycle.
REQ-029 The non-owner SHALL never see ready or rsp_valid while a frame is open, whatever its valid, and regardless of mtds_rdy.
REQ-030 mtds_rdy SHALL be evaluated only in IDLE; a deassertion mid-frame SHALL not affect the frame.
REQ-031 Outputs io1_o=0 and io1_t=1 SHALL be constant; ss_t, sck_t and io0_t SHALL be 0 out of reset.
REQ-032 The clock divider, bit counter and setup/gap counter SHALL be sized to the parameters and SHALL not wrap within a byte.

Reset
REQ-033 While resetn=0 at a clk edge, the block SHALL return to IDLE with: ss_o=1, sck_o=0, io0_o=0, ready=0, rsp_valid=0, busy=0, grant=0.
REQ-034 Reset SHALL clear the round-robin pointer so that requester 0 wins the first tie.
REQ-035 Reset during SHIFT SHALL abort the byte with ss_o=1 in the next cycle; no rsp_valid SHALL be issued for the partial byte.

Verification (CLK_DIV=2, CS_SETUP=2, MISO looped to MOSI)
REQ-036 Single-byte frame: req0 0xA5 last=1, rdy=1 -> one req0_ready, 8 SCK pulses, rsp0_data=0xA5, SS low for 34 cycles, then 2 cycles high before idle.
REQ-037 Tie: req0 and req1 valid together after reset -> req0 frame first, then req1 frame, separated by the 2-cycle SS gap.
REQ-038 Frame 0x12,0x34 with a 5-cycle valid gap -> HOLD keeps SS low and SCK low; rsp bytes are 0x12 then 0x34; no req1 service in between.
REQ-039 mtds_rdy=0 with req1 valid -> no ready, SS stays high; rdy rising -> frame starts in the next cycle.
REQ-040 resetn pulsed low mid-byte -> SS high the next cycle, no rsp_valid, busy=0; a new request afterwards completes normally.
